// File: rtl/vector_lsu_strided_pkg.sv
// Shared types and defaults for the strided vector load/store unit.
package vector_lsu_strided_pkg;

  localparam int unsigned DEF_MAX_LEN         = 64;
  localparam int unsigned DEF_MAX_OUTSTANDING = 8;
  localparam int unsigned DEF_ELEM_WIDTH      = 64;
  localparam int unsigned DEF_IDX_W           = $clog2(DEF_MAX_LEN);

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_LOAD,
    LSU_STORE,
    LSU_DONE
  } lsu_state_e;

  typedef struct packed {
    logic [DEF_IDX_W-1:0]      id;
    logic [DEF_ELEM_WIDTH-1:0] data;
  } lsu_rsp_t;

endpackage

// File: rtl/vector_lsu_strided_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; push at full is accepted only alongside a pop.
module lsu_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vector_lsu_strided.sv
// Strided vector load/store unit: one command at a time, bounded in-flight requests, out-of-order load returns.
module vector_lsu_strided
  import vector_lsu_strided_pkg::*;
#(
  parameter int unsigned CORE_ID         = 8,
  parameter int unsigned ELEM_WIDTH      = 64,
  parameter int unsigned MAX_LEN         = DEF_MAX_LEN,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned LEN_W           = $clog2(MAX_LEN) + 1,
  parameter int unsigned IDX_W           = $clog2(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_is_store,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [4:0]            cmd_vreg,
  output logic                  done,
  output logic                  reg_rd_vld,
  input  logic                  reg_rd_grant,
  output logic [4:0]            reg_rd_vreg,
  output logic [IDX_W-1:0]      reg_rd_idx,
  input  logic                  reg_rd_rsp_vld,
  input  logic [ELEM_WIDTH-1:0] reg_rd_rsp_data,
  output logic                  reg_wr_vld,
  input  logic                  reg_wr_grant,
  output logic [4:0]            reg_wr_vreg,
  output logic [IDX_W-1:0]      reg_wr_idx,
  output logic [ELEM_WIDTH-1:0] reg_wr_data,
  output logic                  mem_req_vld,
  input  logic                  mem_req_grant,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [IDX_W-1:0]      mem_req_id,
  output logic [7:0]            mem_req_core_id,
  output logic [ELEM_WIDTH-1:0] mem_req_data,
  input  logic                  mem_rsp_vld,
  input  logic [IDX_W-1:0]      mem_rsp_id,
  input  logic [ELEM_WIDTH-1:0] mem_rsp_data
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned SUM_W = OUT_W + 1;
  localparam int unsigned RSP_W = IDX_W + ELEM_WIDTH;

  lsu_state_e            state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [4:0]            vreg_q, vreg_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      iss_q, iss_d;
  logic [LEN_W-1:0]      comp_q, comp_d;
  logic [LEN_W-1:0]      rd_q, rd_d;
  logic [OUT_W-1:0]      out_q, out_d;
  logic [OUT_W-1:0]      fu_q, fu_d;

  logic             in_load, in_store, can_issue;
  logic             req_vld, req_fire, rd_vld, rd_fire, wr_vld, wr_fire;
  logic             rsp_ok, rsp_push, ack, cmp_inc;
  logic             rsp_full, rsp_empty, sd_full, sd_empty;
  logic [RSP_W-1:0] rsp_head;
  logic [ELEM_WIDTH-1:0] sd_head;
  logic             unused_full;

  assign in_load   = (state_q == LSU_LOAD);
  assign in_store  = (state_q == LSU_STORE);
  assign can_issue = (out_q < OUT_W'(MAX_OUTSTANDING));

  assign req_vld  = can_issue && ((in_load && (iss_q < len_q)) || (in_store && !sd_empty));
  assign req_fire = req_vld && mem_req_grant;
  // Reads are throttled so fetched-but-unsent plus in-flight never exceeds the FIFO depth.
  assign rd_vld   = in_store && (rd_q < len_q) &&
                    ((SUM_W'(fu_q) + SUM_W'(out_q)) < SUM_W'(MAX_OUTSTANDING));
  assign rd_fire  = rd_vld && reg_rd_grant;
  assign wr_vld   = in_load && !rsp_empty;
  assign wr_fire  = wr_vld && reg_wr_grant;
  assign rsp_ok   = mem_rsp_vld && (LEN_W'(mem_rsp_id) < len_q);
  assign rsp_push = in_load && rsp_ok;
  assign ack      = in_store && rsp_ok;
  assign cmp_inc  = wr_fire || ack;
  assign unused_full = rsp_full ^ sd_full;

  lsu_fifo #(.WIDTH(RSP_W), .DEPTH(MAX_OUTSTANDING)) u_rsp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_push),
    .wdata ({mem_rsp_id, mem_rsp_data}),
    .pop   (wr_fire),
    .rdata (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty)
  );

  lsu_fifo #(.WIDTH(ELEM_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_sd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_store && reg_rd_rsp_vld),
    .wdata (reg_rd_rsp_data),
    .pop   (in_store && req_fire),
    .rdata (sd_head),
    .full  (sd_full),
    .empty (sd_empty)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    vreg_d   = vreg_q;
    stride_d = stride_q;
    addr_d   = req_fire ? (addr_q + stride_q) : addr_q;
    iss_d    = iss_q + LEN_W'(req_fire);
    comp_d   = comp_q + LEN_W'(cmp_inc);
    rd_d     = rd_q + LEN_W'(rd_fire);
    out_d    = out_q + OUT_W'(req_fire) - OUT_W'(cmp_inc);
    fu_d     = fu_q + OUT_W'(rd_fire) - OUT_W'(in_store && req_fire);
    unique case (state_q)
      LSU_IDLE: begin
        if (cmd_vld) begin
          len_d    = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
          vreg_d   = cmd_vreg;
          stride_d = cmd_stride;
          addr_d   = cmd_base;
          iss_d    = '0;
          comp_d   = '0;
          rd_d     = '0;
          out_d    = '0;
          fu_d     = '0;
          if (cmd_len == '0)     state_d = LSU_DONE;
          else if (cmd_is_store) state_d = LSU_STORE;
          else                   state_d = LSU_LOAD;
        end
      end
      LSU_LOAD, LSU_STORE: begin
        if (comp_q == len_q) state_d = LSU_DONE;
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LSU_IDLE;
      len_q    <= '0;
      vreg_q   <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      iss_q    <= '0;
      comp_q   <= '0;
      rd_q     <= '0;
      out_q    <= '0;
      fu_q     <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      vreg_q   <= vreg_d;
      stride_q <= stride_d;
      addr_q   <= addr_d;
      iss_q    <= iss_d;
      comp_q   <= comp_d;
      rd_q     <= rd_d;
      out_q    <= out_d;
      fu_q     <= fu_d;
    end
  end

  // Payload fields are gated by their valid so idle outputs read as zero.
  assign cmd_rdy         = (state_q == LSU_IDLE);
  assign done            = (state_q == LSU_DONE);
  assign mem_req_vld     = req_vld;
  assign mem_req_write   = req_vld && in_store;
  assign mem_req_addr    = req_vld ? addr_q : '0;
  assign mem_req_id      = req_vld ? iss_q[IDX_W-1:0] : '0;
  assign mem_req_core_id = req_vld ? 8'(CORE_ID) : '0;
  assign mem_req_data    = (req_vld && in_store) ? sd_head : '0;
  assign reg_rd_vld      = rd_vld;
  assign reg_rd_vreg     = rd_vld ? vreg_q : '0;
  assign reg_rd_idx      = rd_vld ? rd_q[IDX_W-1:0] : '0;
  assign reg_wr_vld      = wr_vld;
  assign reg_wr_vreg     = wr_vld ? vreg_q : '0;
  assign reg_wr_idx      = wr_vld ? rsp_head[RSP_W-1 -: IDX_W] : '0;
  assign reg_wr_data     = wr_vld ? rsp_head[ELEM_WIDTH-1:0] : '0;

endmodule
